// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: requester/response bus for the shared adder arbiter
interface adder_arbiter_if #(
  parameter int ADDER_WIDTH = 116,
  parameter int NUM_REQ = 4,
  parameter int REQ_IDX_W = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a;
  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [REQ_IDX_W-1:0] rsp_id;
  logic [ADDER_WIDTH:0] rsp_sum;
  logic [31:0] stat_ops;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_sum, stat_ops
  );
  modport slave (
    input req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, stat_ops
  );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin scheduler for one two-stage registered adder
// ADDER_ARB_STATS_EN enables the saturating completed-operation counter on stat_ops.
module adder_arbiter #(
  parameter int ADDER_WIDTH = 116,
  parameter int NUM_REQ = 4,
  parameter int REQ_IDX_W = 2
) (
  input logic clk,
  input logic rst_n,
  adder_arbiter_if.slave bus
);
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] g;
  logic [REQ_IDX_W-1:0] idx;
  logic found;
  logic stall;
  logic accept;
  logic s1_valid;
  logic [ADDER_WIDTH-1:0] s1_a;
  logic [ADDER_WIDTH-1:0] s1_b;
  logic [REQ_IDX_W-1:0] s1_id;
  logic rsp_valid;
  logic [REQ_IDX_W-1:0] rsp_id;
  logic [ADDER_WIDTH:0] rsp_sum;
  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = REQ_IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign stall = rsp_valid & ~bus.rsp_ready;
  assign accept = found & ~stall;
  assign bus.req_ready = accept ? NUM_REQ'(1) << g : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_id <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_sum <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= bus.req_a[int'(g)*ADDER_WIDTH +: ADDER_WIDTH];
        s1_b <= bus.req_b[int'(g)*ADDER_WIDTH +: ADDER_WIDTH];
        s1_id <= g;
        rr_ptr <= (g == REQ_IDX_W'(NUM_REQ-1)) ? '0 : g + 1'b1;
      end
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_sum <= {1'b0, s1_a} + {1'b0, s1_b};
        rsp_id <= s1_id;
      end
    end
  end
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_sum = rsp_sum;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0] ops;
  always_ff @(posedge clk) begin
    if (!rst_n) ops <= '0;
    else if (rsp_valid && bus.rsp_ready && ops != 32'hFFFF_FFFF) ops <= ops + 32'd1;
  end
  assign bus.stat_ops = ops;
`else
  assign bus.stat_ops = '0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed checks for reset flush, carry, fairness, backpressure, sparse grants, stats
module tb_adder_arbiter;
  localparam int W = 116;
  localparam int N = 4;
  localparam int IW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  adder_arbiter_if #(.ADDER_WIDTH(W), .NUM_REQ(N), .REQ_IDX_W(IW)) bus ();
  adder_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .REQ_IDX_W(IW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    logic [127:0] carry_sum;
    carry_sum = 128'd1 << W;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("reset_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    check("reset_rsp_sum", 128'(bus.rsp_sum), 128'd0);
    check("reset_rsp_id", 128'(bus.rsp_id), 128'd0);
    check("reset_stat_ops", 128'(bus.stat_ops), 128'd0);
    check("reset_req_ready", 128'(bus.req_ready), 128'd0);
    // reset flush: accepted op must never come out
    step(); bus.req_valid = 4'b0001; set_op(0, 116'd3, 116'd4); #1;
    check("flush_accept", 128'(bus.req_ready), 128'd1);
    step(); bus.req_valid = '0; rst_n = 1'b0;
    step(); rst_n = 1'b1; #1;
    check("flush_rsp_valid", 128'(bus.rsp_valid), 128'd0);
    check("flush_rsp_sum", 128'(bus.rsp_sum), 128'd0);
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      check("flush_no_rsp", 128'(bus.rsp_valid), 128'd0);
    end
    // carry-out from requester 2
    step(); bus.req_valid = 4'b0100; set_op(2, {W{1'b1}}, 116'd1); #1;
    check("carry_ready", 128'(bus.req_ready), 128'd4);
    step(); bus.req_valid = '0; #1;
    check("carry_latency", 128'(bus.rsp_valid), 128'd0);
    step(); #1;
    check("carry_rsp_valid", 128'(bus.rsp_valid), 128'd1);
    check("carry_sum", 128'(bus.rsp_sum), carry_sum);
    check("carry_id", 128'(bus.rsp_id), 128'd2);
    step(); #1;
    check("carry_drain", 128'(bus.rsp_valid), 128'd0);
    // sparse: rr_ptr is 3 here
    step(); bus.req_valid = 4'b0010; set_op(1, 116'd1, 116'd2); #1;
    check("sparse_r1_ready", 128'(bus.req_ready), 128'd2);
    step(); bus.req_valid = 4'b1000; set_op(3, 116'd100, 116'd23); #1;
    check("sparse_ptr2", 128'(dut.rr_ptr), 128'd2);
    check("sparse_r3_ready", 128'(bus.req_ready), 128'd8);
    step(); bus.req_valid = '0; #1;
    check("sparse_ptr0", 128'(dut.rr_ptr), 128'd0);
    check("sparse_rsp1_id", 128'(bus.rsp_id), 128'd1);
    check("sparse_rsp1_sum", 128'(bus.rsp_sum), 128'd3);
    step(); #1;
    check("sparse_rsp3_id", 128'(bus.rsp_id), 128'd3);
    check("sparse_rsp3_sum", 128'(bus.rsp_sum), 128'd123);
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    // round robin: sums 10,13,16,19 for requesters 0..3
    for (int i = 0; i < N; i++) set_op(i, W'(10 + i), W'(2 * i));
    for (int k = 0; k <= 10; k++) begin
      step(); bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000; #1;
      if (k < 8) check("rr_grant", 128'(bus.req_ready), 128'(4'b0001 << (k % 4)));
      if (k >= 2 && k < 10) begin
        check("rr_rsp_valid", 128'(bus.rsp_valid), 128'd1);
        check("rr_rsp_id", 128'(bus.rsp_id), 128'((k - 2) % 4));
        check("rr_rsp_sum", 128'(bus.rsp_sum), 128'(10 + 3 * ((k - 2) % 4)));
      end
      if (k == 10) check("rr_drain", 128'(bus.rsp_valid), 128'd0);
    end
    // backpressure: 5+7 stalls 3 cycles while requester 1 waits with 10+20
    step(); bus.req_valid = 4'b0001; set_op(0, 116'd5, 116'd7); set_op(1, 116'd10, 116'd20); #1;
    check("bp_op0_ready", 128'(bus.req_ready), 128'd1);
    step(); bus.req_valid = '0;
    step(); bus.req_valid = 4'b0010; bus.rsp_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin step(); #1; end
      check("bp_stall_ready", 128'(bus.req_ready), 128'd0);
      check("bp_stall_valid", 128'(bus.rsp_valid), 128'd1);
      check("bp_stall_sum", 128'(bus.rsp_sum), 128'd12);
      check("bp_stall_id", 128'(bus.rsp_id), 128'd0);
    end
    step(); bus.rsp_ready = 1'b1; #1;
    check("bp_release_ready", 128'(bus.req_ready), 128'd2);
    step(); bus.req_valid = '0; #1;
    check("bp_no_dup", 128'(bus.rsp_valid), 128'd0);
    step(); #1;
    check("bp_op1_valid", 128'(bus.rsp_valid), 128'd1);
    check("bp_op1_sum", 128'(bus.rsp_sum), 128'd30);
    check("bp_op1_id", 128'(bus.rsp_id), 128'd1);
    step(); #1;
    check("bp_drain", 128'(bus.rsp_valid), 128'd0);
`ifdef ADDER_ARB_STATS_EN
    check("stat_ops", 128'(bus.stat_ops), 128'd10);
`else
    check("stat_ops", 128'(bus.stat_ops), 128'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one registered wide adder between NUM_REQ requesters. Each requester uses a valid/ready handshake.
- Grants are round-robin, one operation per cycle. The adder is a two-stage pipeline: operand registers, then a sum register.
- Each result returns on a single response port, tagged with the requester index, with backpressure.
- Sits in front of the arithmetic benchmark adders as their scheduler.

Parameters:
- ADDER_WIDTH, 116, operand width; sum is ADDER_WIDTH+1 bits.
- NUM_REQ, 4, number of requesters (2..16).
- REQ_IDX_W, 2, width of requester index; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*ADDER_WIDTH  operand A; requester i at slice [i*ADDER_WIDTH +: ADDER_WIDTH].
- req_b  in  NUM_REQ*ADDER_WIDTH  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  REQ_IDX_W  index of the requester that issued the result.
- rsp_sum  out  ADDER_WIDTH+1  a+b, including carry-out in the MSB.
- stat_ops  out  32  completed-operation count (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge): rr_ptr=0; s1_valid=0; rsp_valid=0; rsp_id=0; rsp_sum=0; stat_ops=0; operand registers cleared. Reset overrides everything and flushes in-flight operations with no response.
- stall = rsp_valid & ~rsp_ready. While stall is high, all pipeline registers hold and req_ready is all zero.
- Grant (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit is the winner g; req_ready = onehot(g) when ~stall, else 0.
  - req_ready never depends on rsp_ready except through stall.
- Accept (req_valid[g] & req_ready[g] at an edge):
  - s1_a <= slice g of req_a; s1_b <= slice g of req_b; s1_id <= g; s1_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ, so the last winner becomes lowest priority.
- No accept and ~stall: s1_valid <= 0; rr_ptr unchanged.
- Stage 2 (~stall):
  - rsp_valid <= s1_valid.
  - If s1_valid: rsp_sum <= s1_a + s1_b, zero-extended to ADDER_WIDTH+1; rsp_id <= s1_id.
- Latency and throughput:
  - Accept at edge T gives rsp_valid high after edge T+1 (visible during cycle T+1..T+2). Two register stages: operands, then sum.
  - Throughput is one operation per cycle with no stalls.
- rsp_sum and rsp_id are stable while rsp_valid & ~rsp_ready.
- Requesters may drop req_valid at any time; no grant is held across cycles.
- Single requester: it is granted every cycle.
- All requesters idle: pipeline drains to rsp_valid=0.
- Simultaneous accept at stage 1 and response handshake: both occur in the same cycle, with no bubble.

Optional Feature:
- Macro: ADDER_ARB_STATS_EN.
- Defined: stat_ops increments by 1 on each response handshake (rsp_valid & rsp_ready). It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: stat_ops is tied to 0, no counter logic exists, and the port list is unchanged.

Test Plan:
- Reset flush: accept an operation, assert rst_n=0 one cycle later. Required: rsp_valid=0, rsp_sum=0, and no response ever appears for that operation.
- Carry-out: requester 2 presents a = all-ones (116 bits), b = 1. Required: two cycles after accept, rsp_sum[116]=1, rsp_sum[115:0]=0, rsp_id=2.
- Round-robin fairness:
  - Stimulus: all 4 requesters hold req_valid=1 for 8 cycles with rsp_ready=1.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required response ids follow the same order, 2 cycles delayed, with no gaps.
- Backpressure:
  - Stimulus: continuous requests, rsp_ready=0 for 3 cycles.
  - Required: req_ready=0 during the stall; rsp_sum and rsp_id frozen; no operation lost or duplicated after release.
  - Example operands: a=5, b=7 gives 12; a=10, b=20 gives 30; results in issue order.
- Sparse requests: only requester 1 is valid, then only requester 3. Required: each is granted the same cycle it asserts; rr_ptr becomes 2, then 0.
- Stats (ADDER_ARB_STATS_EN defined): complete 10 responses. Required: stat_ops=10. Without the macro: stat_ops stays 0.
